// File: rtl/rs_cmd_queue_bridge.sv
// Avalon-MM bridge between the HPS lightweight bus and the RS 16/14 controller.
// It queues encode/decode commands, dispatches them one at a time, records completions and passes RAM accesses through.
`timescale 1ns/1ps
module rs_cmd_queue_bridge #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int SEL_LSB      = 8,
  parameter int CMD_DEPTH    = 4,
  parameter int STS_DEPTH    = 4,
  parameter int DONE_TIMEOUT = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              chipselect_i,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [31:0]       address_i,
  input  logic [DATA_W-1:0] writedata_i,
  output logic [DATA_W-1:0] readdata_o,
  output logic              readdatavalid_o,
  output logic              waitrequest_o,
  output logic              hps_mem_stb_o,
  output logic              hps_mem_write_o,
  output logic [DATA_W-1:0] hps_mem_wdata_o,
  output logic [ADDR_W-1:0] hps_mem_addr_o,
  input  logic [DATA_W-1:0] hps_mem_rdata_i,
  input  logic              hps_mem_rdy_i,
  output logic              hps_rs_exec_o,
  output logic              hps_rs_en_decn_o,
  output logic [ADDR_W-1:0] hps_rs_addr_o,
  input  logic              encode_done_i,
  input  logic              decode_done_i,
  input  logic              dec_cerr_i,
  input  logic              dec_ncerr_i,
  output logic              irq_o
);
  localparam int CW = $clog2(CMD_DEPTH);
  localparam int SW = $clog2(STS_DEPTH);
  localparam int TW = $clog2(DONE_TIMEOUT + 1);

  typedef enum logic [1:0] {D_IDLE, D_ISSUE, D_BUSY, D_RECORD} dstate_t;
  typedef enum logic [1:0] {M_IDLE, M_STB, M_WAIT} mstate_t;

  dstate_t dstate;
  mstate_t mstate;

  logic [2:0] sel;
  logic       req, wr, rd, sel_ram, sel_cmd, accept;
  logic       unused;

  assign sel     = address_i[SEL_LSB+2:SEL_LSB];
  assign req     = chipselect_i & (read_i | write_i);
  assign wr      = write_i;
  assign rd      = read_i & ~write_i;
  assign sel_ram = (sel == 3'b000);
  assign sel_cmd = (sel[2:1] == 2'b01);
  assign unused  = &{1'b0, address_i};

  logic [ADDR_W:0]   cmd_mem [CMD_DEPTH];
  logic [CW-1:0]     cmd_wp, cmd_rp;
  logic [CW:0]       cmd_cnt;
  logic              cmd_full, cmd_push, cmd_pop;

  logic [DATA_W-1:0] sts_mem [STS_DEPTH];
  logic [SW-1:0]     sts_wp, sts_rp;
  logic [SW:0]       sts_cnt, sts_cnt_next;
  logic              sts_full, sts_push, sts_pop;

  logic [TW-1:0]     tmo_cnt;
  logic              rec_cerr, rec_ncerr, rec_tmo, done_match;
  logic [DATA_W-1:0] sts_word, occ_word, rd_word;

  assign cmd_full = (cmd_cnt == (CW+1)'(CMD_DEPTH));
  assign sts_full = (sts_cnt == (SW+1)'(STS_DEPTH));

  // RAM accesses hold the bus until the RAM answers; command writes stall only while the queue is full.
  always_comb begin
    waitrequest_o = 1'b0;
    if (req) begin
      if (sel_ram)            waitrequest_o = !(mstate == M_WAIT && hps_mem_rdy_i);
      else if (wr && sel_cmd) waitrequest_o = cmd_full;
    end
  end

  assign accept     = req & ~waitrequest_o;
  assign cmd_push   = accept & wr & sel_cmd;
  assign cmd_pop    = (dstate == D_IDLE) && (cmd_cnt != '0);
  assign sts_pop    = accept & rd & (sel == 3'b100) & (sts_cnt != '0);
  assign sts_push   = (dstate == D_RECORD) && (!sts_full || sts_pop);
  assign done_match = hps_rs_en_decn_o ? encode_done_i : decode_done_i;
  assign sts_cnt_next = sts_cnt + (SW+1)'(sts_push) - (SW+1)'(sts_pop);

  always_comb begin
    sts_word = '0;
    sts_word[31] = 1'b1;
    sts_word[30] = hps_rs_en_decn_o;
    sts_word[10] = rec_tmo;
    sts_word[9]  = rec_ncerr;
    sts_word[8]  = rec_cerr;
    sts_word[ADDR_W-1:0] = hps_rs_addr_o;
  end

  always_comb begin
    occ_word = '0;
    occ_word[7:0]  = 8'(cmd_cnt);
    occ_word[15:8] = 8'(sts_cnt);
    occ_word[16]   = (dstate != D_IDLE);
    occ_word[17]   = (mstate != M_IDLE);
  end

  always_comb begin
    rd_word = '0;
    case (sel)
      3'b100:  rd_word = (sts_cnt != '0) ? sts_mem[sts_rp] : '0;
      3'b101:  rd_word = occ_word;
      default: rd_word = '0;
    endcase
  end

  // Avalon side: register reads answer next cycle, RAM accesses run stb -> wait for rdy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mstate          <= M_IDLE;
      hps_mem_stb_o   <= 1'b0;
      hps_mem_write_o <= 1'b0;
      hps_mem_wdata_o <= '0;
      hps_mem_addr_o  <= '0;
      readdata_o      <= '0;
      readdatavalid_o <= 1'b0;
    end else begin
      readdatavalid_o <= 1'b0;
      hps_mem_stb_o   <= 1'b0;
      case (mstate)
        M_IDLE: if (req && sel_ram && dstate == D_IDLE && cmd_cnt == '0) begin
          hps_mem_stb_o   <= 1'b1;
          hps_mem_write_o <= wr;
          hps_mem_addr_o  <= address_i[ADDR_W-1:0];
          hps_mem_wdata_o <= writedata_i;
          mstate          <= M_STB;
        end
        M_STB:  mstate <= M_WAIT;
        M_WAIT: if (hps_mem_rdy_i) begin
          mstate <= M_IDLE;
          if (!hps_mem_write_o) begin
            readdata_o      <= hps_mem_rdata_i;
            readdatavalid_o <= 1'b1;
          end
        end
        default: mstate <= M_IDLE;
      endcase
      if (accept && rd && !sel_ram) begin
        readdata_o      <= rd_word;
        readdatavalid_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) if (cmd_push) cmd_mem[cmd_wp] <= {sel[0], address_i[ADDR_W-1:0]};
  always_ff @(posedge clk_i) if (sts_push) sts_mem[sts_wp] <= sts_word;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmd_wp  <= '0;
      cmd_rp  <= '0;
      cmd_cnt <= '0;
      sts_wp  <= '0;
      sts_rp  <= '0;
      sts_cnt <= '0;
      irq_o   <= 1'b0;
    end else begin
      if (cmd_push) cmd_wp <= cmd_wp + 1'b1;
      if (cmd_pop)  cmd_rp <= cmd_rp + 1'b1;
      cmd_cnt <= cmd_cnt + (CW+1)'(cmd_push) - (CW+1)'(cmd_pop);
      if (sts_push) sts_wp <= sts_wp + 1'b1;
      if (sts_pop)  sts_rp <= sts_rp + 1'b1;
      sts_cnt <= sts_cnt_next;
      irq_o   <= (sts_cnt_next != '0);
    end
  end

  // Dispatcher: mode/address stay on the RS port from issue until the status is recorded.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dstate           <= D_IDLE;
      hps_rs_exec_o    <= 1'b0;
      hps_rs_en_decn_o <= 1'b0;
      hps_rs_addr_o    <= '0;
      tmo_cnt          <= '0;
      rec_cerr         <= 1'b0;
      rec_ncerr        <= 1'b0;
      rec_tmo          <= 1'b0;
    end else begin
      hps_rs_exec_o <= 1'b0;
      case (dstate)
        D_IDLE: if (cmd_cnt != '0) begin
          {hps_rs_en_decn_o, hps_rs_addr_o} <= cmd_mem[cmd_rp];
          hps_rs_exec_o <= 1'b1;
          dstate        <= D_ISSUE;
        end
        D_ISSUE: begin
          tmo_cnt <= TW'(1);
          dstate  <= D_BUSY;
        end
        D_BUSY: begin
          if (done_match) begin
            rec_cerr  <= !hps_rs_en_decn_o && dec_cerr_i;
            rec_ncerr <= !hps_rs_en_decn_o && dec_ncerr_i;
            rec_tmo   <= 1'b0;
            dstate    <= D_RECORD;
          end else if (tmo_cnt >= TW'(DONE_TIMEOUT)) begin
            rec_cerr  <= 1'b0;
            rec_ncerr <= 1'b0;
            rec_tmo   <= 1'b1;
            dstate    <= D_RECORD;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        D_RECORD: if (sts_push) begin
          hps_rs_en_decn_o <= 1'b0;
          hps_rs_addr_o    <= '0;
          tmo_cnt          <= '0;
          dstate           <= D_IDLE;
        end
        default: dstate <= D_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rs_cmd_queue_bridge.sv
// Directed bench for rs_cmd_queue_bridge: expected read data and exec pulses go into
// scoreboards that monitors drain whenever the DUT strobes readdatavalid or exec.
`timescale 1ns/1ps
module tb_rs_cmd_queue_bridge;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic clk_i = 1'b0;
  logic rst_i, chipselect_i, read_i, write_i;
  logic [31:0] address_i;
  logic [DATA_W-1:0] writedata_i, readdata_o, hps_mem_wdata_o, hps_mem_rdata_i;
  logic readdatavalid_o, waitrequest_o, hps_mem_stb_o, hps_mem_write_o, hps_mem_rdy_i;
  logic [ADDR_W-1:0] hps_mem_addr_o, hps_rs_addr_o;
  logic hps_rs_exec_o, hps_rs_en_decn_o, encode_done_i, decode_done_i, dec_cerr_i, dec_ncerr_i, irq_o;

  always #5 clk_i = ~clk_i;

  rs_cmd_queue_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_LSB(8), .CMD_DEPTH(4),
                        .STS_DEPTH(4), .DONE_TIMEOUT(1024)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .chipselect_i(chipselect_i), .read_i(read_i), .write_i(write_i),
    .address_i(address_i), .writedata_i(writedata_i), .readdata_o(readdata_o),
    .readdatavalid_o(readdatavalid_o), .waitrequest_o(waitrequest_o),
    .hps_mem_stb_o(hps_mem_stb_o), .hps_mem_write_o(hps_mem_write_o), .hps_mem_wdata_o(hps_mem_wdata_o),
    .hps_mem_addr_o(hps_mem_addr_o), .hps_mem_rdata_i(hps_mem_rdata_i), .hps_mem_rdy_i(hps_mem_rdy_i),
    .hps_rs_exec_o(hps_rs_exec_o), .hps_rs_en_decn_o(hps_rs_en_decn_o), .hps_rs_addr_o(hps_rs_addr_o),
    .encode_done_i(encode_done_i), .decode_done_i(decode_done_i), .dec_cerr_i(dec_cerr_i),
    .dec_ncerr_i(dec_ncerr_i), .irq_o(irq_o));

  typedef struct { logic [31:0] data; string name; } rd_exp_t;
  rd_exp_t     rd_q[$];
  logic [8:0]  exec_q[$];
  logic [31:0] mem [256];
  int n_checks = 0, n_pass = 0, cyc = 0, acc_cyc = 0, exec_cnt = 0, stb_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Scoreboard monitors
  always @(negedge clk_i) begin
    if (readdatavalid_o) begin
      if (rd_q.size() == 0) check("spurious readdatavalid", readdatavalid_o, 0);
      else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        check(e.name, readdata_o, e.data);
        check("readdatavalid latency", cyc - acc_cyc, 1);
      end
    end
    if (hps_rs_exec_o) begin
      exec_cnt++;
      if (exec_q.size() == 0) check("spurious exec", hps_rs_exec_o, 0);
      else check("exec order", {hps_rs_en_decn_o, hps_rs_addr_o}, exec_q.pop_front());
    end
  end

  // RAM model: answers each strobe two cycles later
  initial begin
    hps_mem_rdy_i = 1'b0;
    hps_mem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (hps_mem_stb_o) begin
        logic [31:0] d;
        stb_cnt++;
        d = mem[hps_mem_addr_o];
        if (hps_mem_write_o) mem[hps_mem_addr_o] = hps_mem_wdata_o;
        repeat (2) @(negedge clk_i);
        hps_mem_rdata_i = hps_mem_write_o ? 32'h0 : d;
        hps_mem_rdy_i = 1'b1;
        @(negedge clk_i);
        hps_mem_rdy_i = 1'b0;
      end
    end
  end

  task automatic av(input logic wr, input logic rd, input logic [31:0] addr, input logic [31:0] wd,
                    output int waits);
    @(negedge clk_i);
    chipselect_i = 1'b1; write_i = wr; read_i = rd; address_i = addr; writedata_i = wd;
    waits = 0;
    forever begin
      #1;
      if (!waitrequest_o) break;
      @(negedge clk_i);
      waits++;
      if (waits > 3000) begin check("waitrequest bound", waitrequest_o, 0); break; end
    end
    acc_cyc = cyc;
    @(posedge clk_i);
    @(negedge clk_i);
    chipselect_i = 1'b0; write_i = 1'b0; read_i = 1'b0;
  endtask

  task automatic rd_chk(input logic [31:0] addr, input logic [31:0] exp, input string name);
    int w;
    rd_q.push_back('{exp, name});
    av(1'b0, 1'b1, addr, 32'h0, w);
  endtask

  task automatic q_cmd(input logic enc, input logic [7:0] a, output int w);
    exec_q.push_back({enc, a});
    av(1'b1, 1'b0, (enc ? 32'h300 : 32'h200) | {24'h0, a}, 32'h0, w);
  endtask

  task automatic wait_exec(input int n);
    int t = 0;
    while (exec_cnt < n && t < 3000) begin @(negedge clk_i); t++; end
    check("exec seen", exec_cnt, n);
  endtask

  task automatic pulse(input logic enc, input logic ce, input logic nce);
    @(negedge clk_i);
    encode_done_i = enc; decode_done_i = !enc; dec_cerr_i = ce; dec_ncerr_i = nce;
    @(negedge clk_i);
    encode_done_i = 0; decode_done_i = 0; dec_cerr_i = 0; dec_ncerr_i = 0;
  endtask

  logic [31:0] ram_data [4] = '{32'h01234567, 32'h89ABCDEF, 32'h01234567, 32'h89ABEFC5};
  logic [7:0]  adr5 [5] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10};
  logic        done5;
  int          w, w5, s0, e0, t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    rst_i = 1; chipselect_i = 0; read_i = 0; write_i = 0; address_i = 0; writedata_i = 0;
    encode_done_i = 0; decode_done_i = 0; dec_cerr_i = 0; dec_ncerr_i = 0;
    repeat (3) @(negedge clk_i);
    check("reset outputs", {readdatavalid_o, waitrequest_o, hps_mem_stb_o, hps_mem_write_o, hps_rs_exec_o,
                            hps_rs_en_decn_o, irq_o, hps_rs_addr_o, hps_mem_addr_o}, 0);
    check("reset readdata", readdata_o, 0);
    rst_i = 0;
    rd_chk(32'h500, 32'h0, "occupancy after reset");

    // RAM pass-through (write wins over read)
    for (int i = 0; i < 4; i++) begin
      s0 = stb_cnt;
      av(1'b1, 1'b1, i, ram_data[i], w);
      check("stb per ram write", stb_cnt - s0, 1);
    end
    for (int i = 0; i < 4; i++) begin
      s0 = stb_cnt;
      rd_chk(i, ram_data[i], "ram readback");
      check("stb per ram read", stb_cnt - s0, 1);
    end

    // Single encode
    q_cmd(1'b1, 8'h00, w);
    wait_exec(1);
    repeat (40) @(negedge clk_i);
    pulse(1'b1, 0, 0);
    t = 0;
    while (!irq_o && t < 50) begin @(negedge clk_i); t++; end
    check("irq after done", irq_o, 1);
    rd_chk(32'h400, 32'hC0000000, "status encode 0x00");
    repeat (3) @(negedge clk_i);
    check("irq after pop", irq_o, 0);
    rd_chk(32'h400, 32'h0, "status pop empty");

    // Fill the command queue behind a busy decode
    q_cmd(1'b0, 8'h40, w);
    wait_exec(2);
    for (int i = 0; i < 4; i++) q_cmd(1'b1, adr5[i], w);
    done5 = 0;
    fork
      begin q_cmd(1'b1, adr5[4], w5); done5 = 1; end
      begin repeat (30) @(negedge clk_i); check("5th write stalled", done5, 0); pulse(1'b0, 0, 0); end
    join
    check("5th write wait cycles", w5 >= 30, 1);
    rd_chk(32'h400, 32'h80000040, "status decode 0x40");
    rd_chk(32'h500, 32'h00010004, "occupancy queue full");
    for (int i = 0; i < 5; i++) begin
      wait_exec(3 + i);
      repeat (10) @(negedge clk_i);
      pulse(1'b1, 0, 0);
      repeat (8) @(negedge clk_i);
      rd_chk(32'h400, 32'hC0000000 | adr5[i], "status queued encode");
    end

    // Decode error reporting; stray encode_done ignored
    q_cmd(1'b0, 8'h04, w);
    q_cmd(1'b0, 8'h08, w);
    wait_exec(8);
    repeat (5) @(negedge clk_i);
    pulse(1'b1, 0, 0);
    repeat (5) @(negedge clk_i);
    rd_chk(32'h500, 32'h00010001, "stray encode_done ignored");
    pulse(1'b0, 1, 0);
    repeat (8) @(negedge clk_i);
    rd_chk(32'h400, 32'h80000104, "status decode cerr");
    wait_exec(9);
    repeat (5) @(negedge clk_i);
    pulse(1'b0, 0, 1);
    repeat (8) @(negedge clk_i);
    rd_chk(32'h400, 32'h80000208, "status decode ncerr");

    // Timeout
    q_cmd(1'b0, 8'h0C, w);
    wait_exec(10);
    repeat (900) @(negedge clk_i);
    rd_chk(32'h500, 32'h00010000, "still busy before timeout");
    repeat (200) @(negedge clk_i);
    rd_chk(32'h400, 32'h8000040C, "status timeout");
    rd_chk(32'h500, 32'h0, "idle after timeout");

    // Status FIFO back-pressure
    for (int i = 0; i < 5; i++) q_cmd(1'b1, 8'h20 + 8'(4*i), w);
    for (int i = 0; i < 5; i++) begin
      wait_exec(11 + i);
      repeat (3) @(negedge clk_i);
      pulse(1'b1, 0, 0);
    end
    repeat (10) @(negedge clk_i);
    rd_chk(32'h500, 32'h00010400, "held in record");
    rd_chk(32'h400, 32'hC0000020, "status full pop");
    repeat (5) @(negedge clk_i);
    rd_chk(32'h500, 32'h00000400, "released from record");
    for (int i = 1; i < 5; i++) rd_chk(32'h400, 32'hC0000020 + 32'(4*i), "status drain");
    repeat (3) @(negedge clk_i);
    check("irq after drain", irq_o, 0);

    // Reset while busy with queued work
    q_cmd(1'b1, 8'h60, w);
    wait_exec(16);
    pulse(1'b1, 0, 0);
    repeat (8) @(negedge clk_i);
    check("irq pending before reset", irq_o, 1);
    q_cmd(1'b0, 8'h50, w);
    wait_exec(17);
    q_cmd(1'b0, 8'h54, w);
    q_cmd(1'b0, 8'h58, w);
    repeat (5) @(negedge clk_i);
    rd_chk(32'h500, 32'h00010102, "occupancy before reset");
    @(negedge clk_i);
    rst_i = 1;
    exec_q.delete();
    @(negedge clk_i);
    check("outputs after mid-op reset", {readdatavalid_o, waitrequest_o, hps_mem_stb_o, hps_rs_exec_o,
                                         hps_rs_en_decn_o, irq_o, hps_rs_addr_o}, 0);
    rst_i = 0;
    rd_chk(32'h500, 32'h0, "occupancy after mid-op reset");
    e0 = exec_cnt;
    pulse(1'b0, 0, 0);
    repeat (50) @(negedge clk_i);
    check("no exec after reset", exec_cnt - e0, 0);
    rd_chk(32'h400, 32'h0, "status flushed by reset");

    repeat (3) @(negedge clk_i);
    check("read scoreboard drained", rd_q.size(), 0);
    check("exec scoreboard drained", exec_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
